// File: rtl/sbox_lane_engine_if.sv
// Bus bundle for sbox_lane_engine: serial table-load port, symbol stream in/out, FSM debug view.
// Stream handshake: a beat transfers on a CLK edge where valid && ready; valid never waits on ready,
// and once out_valid is high, out_data stays unchanged until that transfer happens.
interface sbox_lane_engine_if #(
  parameter int SBOX_W = 8,
  parameter int LANES  = 4
);
  logic                      cfg_start;
  logic                      cfg_we;
  logic [SBOX_W-1:0]         cfg_data;
  logic                      cfg_busy;
  logic                      cfg_err;
  logic                      tbl_ok;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_inv;
  logic [LANES*SBOX_W-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*SBOX_W-1:0]   out_data;
  logic [1:0]                state_dbg;

  modport master (
    output cfg_start, cfg_we, cfg_data, in_valid, in_inv, in_data, out_ready,
    input  cfg_busy, cfg_err, tbl_ok, in_ready, out_valid, out_data, state_dbg
  );

  modport slave (
    input  cfg_start, cfg_we, cfg_data, in_valid, in_inv, in_data, out_ready,
    output cfg_busy, cfg_err, tbl_ok, in_ready, out_valid, out_data, state_dbg
  );
endinterface

// File: rtl/sbox_lane_engine.sv
// Multi-lane S-box substitution engine: serially loaded forward table, inverse built on the fly,
// bijectivity checked during load, one registered LANES-wide lookup per cycle.
module sbox_lane_engine #(
  parameter int SBOX_W = 8,
  parameter int LANES  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  sbox_lane_engine_if.slave  bus
);
  localparam int DEPTH = 1 << SBOX_W;
  localparam int DW    = LANES * SBOX_W;
  localparam logic [SBOX_W-1:0] LAST_IDX = SBOX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SBOX_W-1:0] fwd_mem [DEPTH];
  logic [SBOX_W-1:0] inv_mem [DEPTH];
  logic [DEPTH-1:0]  used;
  logic [SBOX_W-1:0] load_cnt;
  logic              cfg_err_q;
  logic              out_valid_q;
  logic [DW-1:0]     out_data_q;
  logic [DW-1:0]     lookup;
  logic              start_ok, load_we, dup, fire;
  logic              cfg_busy_c, tbl_ok_c, in_ready_c;

  // A held result blocks a reload so it is never lost; outside RUN out_valid is always 0.
  assign start_ok = bus.cfg_start && !out_valid_q;
  assign load_we  = (state == ST_LOAD) && bus.cfg_we && !bus.cfg_start;
  assign dup      = used[bus.cfg_data];
  assign fire     = bus.in_valid && in_ready_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cfg_busy_c = 1'b0;
    tbl_ok_c   = 1'b0;
    in_ready_c = 1'b0;
    case (state)
      ST_LOAD:  cfg_busy_c = 1'b1;
      ST_RUN: begin
        tbl_ok_c   = 1'b1;
        in_ready_c = !out_valid_q || bus.out_ready;
      end
      default: ;
    endcase
    if (start_ok) begin
      state_nxt = ST_LOAD;
    end else if (load_we && (load_cnt == LAST_IDX)) begin
      // The final write's own duplicate counts toward the verdict.
      state_nxt = (cfg_err_q || dup) ? ST_EMPTY : ST_RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_cnt  <= '0;
      used      <= '0;
      cfg_err_q <= 1'b0;
    end else if (start_ok) begin
      load_cnt  <= '0;
      used      <= '0;
      cfg_err_q <= 1'b0;
    end else if (load_we) begin
      used[bus.cfg_data] <= 1'b1;
      if (dup) cfg_err_q <= 1'b1;
      load_cnt <= load_cnt + SBOX_W'(1);
    end
  end

  // Table RAMs carry no reset; a reload is the only way to make them valid again.
  always_ff @(posedge CLK) begin
    if (load_we) begin
      fwd_mem[load_cnt]     <= bus.cfg_data;
      inv_mem[bus.cfg_data] <= load_cnt;
    end
  end

  always_comb begin
    lookup = '0;
    for (int k = 0; k < LANES; k++) begin
      lookup[k*SBOX_W +: SBOX_W] = bus.in_inv ? inv_mem[bus.in_data[k*SBOX_W +: SBOX_W]]
                                              : fwd_mem[bus.in_data[k*SBOX_W +: SBOX_W]];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lookup;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.cfg_busy  = cfg_busy_c;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.tbl_ok    = tbl_ok_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_sbox_lane_engine.sv
// Bench for sbox_lane_engine: table loads, directed and random lookups checked by a
// queue-based scoreboard against a permutation model.
module tb_sbox_lane_engine;
  localparam int SBOX_W = 8;
  localparam int LANES  = 4;
  localparam int DEPTH  = 1 << SBOX_W;
  localparam int DW     = LANES * SBOX_W;

  logic CLK;
  logic RST;
  int   total = 0;
  int   bad   = 0;
  int   model_fwd [DEPTH];
  logic [DW-1:0] exp_q [$];

  sbox_lane_engine_if #(.SBOX_W(SBOX_W), .LANES(LANES)) bus ();

  sbox_lane_engine #(.SBOX_W(SBOX_W), .LANES(LANES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // reference model: forward is a table read, inverse is a search for the preimage
  function automatic logic [DW-1:0] ref_out(input logic inv, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      int x;
      int y;
      x = int'(d[k*SBOX_W +: SBOX_W]);
      y = 0;
      if (!inv) y = model_fwd[x];
      else for (int j = 0; j < DEPTH; j++) if (model_fwd[j] == x) y = j;
      r[k*SBOX_W +: SBOX_W] = SBOX_W'(y);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*SBOX_W +: SBOX_W] = SBOX_W'($urandom_range(0, DEPTH - 1));
    return r;
  endfunction

  // driver tasks (all start and end just after a rising edge)
  task automatic load_table(input int n);
    bit seen [DEPTH];
    bit err;
    err = 1'b0;
    for (int j = 0; j < DEPTH; j++) seen[j] = 1'b0;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check("load_busy_after_start", bus.cfg_busy, 1'b1);
    check("load_err_cleared", bus.cfg_err, 1'b0);
    check("load_no_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < n; i++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_data = SBOX_W'(model_fwd[i]);
      tick();
      if (seen[model_fwd[i]]) err = 1'b1;
      seen[model_fwd[i]] = 1'b1;
      check("load_err_progress", bus.cfg_err, err);
    end
    bus.cfg_we = 1'b0;
    if (n == DEPTH) begin
      check("load_done_busy", bus.cfg_busy, 1'b0);
      check("load_done_tbl_ok", bus.tbl_ok, !err);
      check("load_done_err", bus.cfg_err, err);
    end
  endtask

  task automatic send(input logic inv, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inv   = inv;
    bus.in_data  = d;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        exp_q.push_back(ref_out(inv, d));
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      logic inv;
      logic [DW-1:0] d;
      inv = logic'(i % 2);
      d   = rand_word();
      bus.in_valid = 1'b1;
      bus.in_inv   = inv;
      bus.in_data  = d;
      @(negedge CLK);
      check("stream_in_ready", bus.in_ready, 1'b1);
      if (i > 0) check("stream_no_bubble", bus.out_valid, 1'b1);
      if (bus.in_ready) exp_q.push_back(ref_out(inv, d));
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_traffic(input int n);
    bit m_full;
    bit acc;
    m_full = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic inv;
      logic [DW-1:0] d;
      inv = logic'($urandom_range(0, 1));
      d   = rand_word();
      bus.in_valid  = logic'($urandom_range(0, 1));
      bus.in_inv    = inv;
      bus.in_data   = d;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      check("rnd_out_valid", bus.out_valid, m_full);
      check("rnd_in_ready", bus.in_ready, !m_full || bus.out_ready);
      acc = bus.in_valid && (!m_full || bus.out_ready);
      if (acc) exp_q.push_back(ref_out(inv, d));
      m_full = acc ? 1'b1 : (bus.out_ready ? 1'b0 : m_full);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic idle(input int n);
    bus.out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // scoreboard monitor: one check per output transfer
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got %0h expected no output", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] x_d, y_d;
    logic [DW-1:0] x_exp;
    RST = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_cfg_busy", bus.cfg_busy, 1'b0);
    check("rst_cfg_err", bus.cfg_err, 1'b0);
    check("rst_tbl_ok", bus.tbl_ok, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // 1: increment table, forward lookup with 1-cycle latency
    for (int i = 0; i < DEPTH; i++) model_fwd[i] = (i + 1) % DEPTH;
    load_table(DEPTH);
    send(1'b0, 32'hFFFE7F00);
    @(negedge CLK);
    check("t1_latency_valid", bus.out_valid, 1'b1);
    check("t1_fwd_value", bus.out_data, 64'h00FF8001);
    tick();

    // 2: inverse lookup, then alternating directions back to back
    send(1'b1, 32'h00FF8001);
    @(negedge CLK);
    check("t2_inv_value", bus.out_data, 64'hFFFE7F00);
    tick();
    stream(12);
    idle(2);

    // 3: backpressure holds the result and blocks input
    bus.out_ready = 1'b0;
    x_d = rand_word();
    y_d = rand_word();
    x_exp = ref_out(1'b0, x_d);
    send(1'b0, x_d);
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b1;
    bus.in_data  = y_d;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("t3_in_ready_low", bus.in_ready, 1'b0);
      check("t3_valid_held", bus.out_valid, 1'b1);
      check("t3_data_held", bus.out_data, x_exp);
      tick();
    end
    bus.out_ready = 1'b1;
    send(1'b1, y_d);
    @(negedge CLK);
    check("t3_next_result", bus.out_valid, 1'b1);
    tick();
    idle(2);

    // 6: reload request while a result is held is ignored
    bus.out_ready = 1'b0;
    x_d = rand_word();
    x_exp = ref_out(1'b0, x_d);
    send(1'b0, x_d);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("t6_busy_low", bus.cfg_busy, 1'b0);
      check("t6_tbl_ok", bus.tbl_ok, 1'b1);
      check("t6_data_held", bus.out_data, x_exp);
      tick();
    end
    idle(2);

    // random traffic on the increment table
    rand_traffic(150);

    // 4: duplicated entry makes the load fail
    for (int i = 0; i < DEPTH; i++) model_fwd[i] = i;
    model_fwd[1] = 0;
    load_table(DEPTH);
    bus.in_valid = 1'b1;
    bus.in_data  = rand_word();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("t4_empty_in_ready", bus.in_ready, 1'b0);
      check("t4_empty_tbl_ok", bus.tbl_ok, 1'b0);
      check("t4_err_sticky", bus.cfg_err, 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;

    // 5: reset in the middle of a load, then a fresh random permutation
    for (int i = 0; i < DEPTH; i++) model_fwd[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = model_fwd[i];
      model_fwd[i] = model_fwd[j];
      model_fwd[j] = t;
    end
    load_table(100);
    RST = 1'b1;
    #1;
    check("t5_rst_busy", bus.cfg_busy, 1'b0);
    check("t5_rst_tbl_ok", bus.tbl_ok, 1'b0);
    check("t5_rst_err", bus.cfg_err, 1'b0);
    check("t5_rst_in_ready", bus.in_ready, 1'b0);
    tick();
    RST = 1'b0;
    tick();
    load_table(DEPTH);
    rand_traffic(200);

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sbox_lane_engine.md
Name: sbox_lane_engine

Overview:
Parametrised, runtime-loadable multi-lane S-box substitution engine for the cipher datapath. It holds one forward table and its automatically built inverse, each 2^SBOX_W entries. It substitutes LANES symbols per cycle in either direction, behind a valid/ready stream interface. The table is loaded serially from the key-schedule/config side and checked for bijectivity while it loads.

Parameters:
SBOX_W, 8, symbol width in bits; table depth is 2^SBOX_W (legal range 4..8)
LANES, 4, symbols substituted per transfer

Ports:
CLK  in  1  clock; all state changes on posedge
RST  in  1  asynchronous, active-high reset
cfg_start  in  1  pulse: begin a table load
cfg_we  in  1  write the next table entry, only while in LOAD
cfg_data  in  SBOX_W  forward value for entry load_cnt
cfg_busy  out  1  high in LOAD
cfg_err  out  1  sticky: last load was not a bijection
tbl_ok  out  1  high only in RUN (valid table present)
in_valid  in  1  input symbols valid
in_ready  out  1  engine accepts input
in_inv  in  1  0 = forward lookup, 1 = inverse lookup
in_data  in  LANES*SBOX_W  lane k at bits [k*SBOX_W +: SBOX_W]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  LANES*SBOX_W  substituted symbols, same lane order

Behaviour:
- Reset (asynchronous, immediate): state=EMPTY; load_cnt=0; cfg_busy=0; cfg_err=0; tbl_ok=0; out_valid=0; out_data=0; all used-flags=0. Table RAM contents are not reset.
- States:
  - EMPTY: no valid table; in_ready=0.
  - LOAD: table being written; in_ready=0; cfg_busy=1.
  - RUN: in_ready = !out_valid | out_ready.
- cfg_start in EMPTY or RUN with out_valid=0:
  - go to LOAD; clear load_cnt, used-flags and cfg_err; tbl_ok drops next cycle.
  - cfg_start while out_valid=1 is ignored (no buffered result is lost).
  - cfg_start in LOAD restarts the load.
- LOAD, on each cfg_we:
  - fwd[load_cnt] <= cfg_data; inv[cfg_data] <= load_cnt.
  - if used[cfg_data] is already 1, set cfg_err; then set used[cfg_data]=1.
  - load_cnt++.
- cfg_we outside LOAD is ignored.
- After the write with load_cnt = 2^SBOX_W-1: next state is RUN if cfg_err=0 (including the error from that final write), else EMPTY. cfg_busy falls the same edge.
- Transfer: in_valid & in_ready at an edge captures all lanes. At that edge out_data lane k <= (in_inv ? inv : fwd)[in_data lane k] and out_valid <= 1. Latency is 1 cycle; throughput is 1 transfer/cycle under continuous out_ready.
- out_valid & !out_ready: out_data and out_valid hold stable and in_ready=0.
- Simultaneous output drain and new input: the new result replaces the old one with no bubble.
- Lanes are independent; all lanes use the same direction per transfer.
- Reset mid-load: returns to EMPTY and the table must be reloaded.

Test Plan:
1. Reset → load fwd[x]=(x+1) mod 256 (256 cfg_we) → cfg_busy falls, tbl_ok=1, cfg_err=0; forward in_data={FF,FE,7F,00} (lane3..0) → out_data={00,FF,80,01} exactly 1 cycle after the handshake.
2. Same table, in_inv=1, in_data={00,FF,80,01} → {FF,FE,7F,00}. Alternate inv/fwd every cycle with out_ready=1 → correct results, no bubbles.
3. Backpressure: out_ready=0 for 5 cycles after a transfer → out_data held, in_ready=0, no input consumed. Release → next queued input appears the following cycle.
4. Bad table: write 0x00 to both entry 0 and entry 1 → cfg_err=1 after the second write; the load completes at 256 writes → state EMPTY, tbl_ok=0, in_ready=0.
5. RST asserted at load_cnt=100 → outputs clear immediately. cfg_start then a full valid load → RUN and correct lookups.
6. cfg_start while out_valid=1 and out_ready=0 → ignored; cfg_busy stays 0 and the held result is unchanged.
